// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction-memory responder on the fetch interface
// Requests arrive on req_valid/req_ready with a 16-bit word address; after
// WAIT_CYCLES wait states the word is returned on rsp_valid/rsp_ready together
// with the full address that produced it. wr_en/wr_addr/wr_data load program
// memory at any time. flush aborts an in-flight fetch and drops a pending
// response. Optional build macro INSTR_BOUNDS_CHECK_EN adds rsp_err: addresses
// >= DEPTH then return a NOP with rsp_err=1 and out-of-range writes are dropped.
module instr_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
`ifdef INSTR_BOUNDS_CHECK_EN
  output logic        rsp_err,
`endif
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [15:0] mem [DEPTH];
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, raddr_q;
  logic        accept, load, ld_oob, wr_ok, unused_wr_hi;
  logic [15:0] ld_addr, rd_word;
  assign req_ready = !reset && !flush && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  // with zero wait states the word is read straight from the incoming address
  assign ld_addr   = accept ? req_addr : addr_q;
`ifdef INSTR_BOUNDS_CHECK_EN
  logic err_q;
  assign ld_oob  = {1'b0, ld_addr} >= 17'(DEPTH);
  assign wr_ok   = {1'b0, wr_addr} < 17'(DEPTH);
  assign rsp_err = err_q;
  always_ff @(posedge clock)
    if (reset) err_q <= 1'b0;
    else if (load) err_q <= ld_oob;
`else
  assign ld_oob = 1'b0;
  assign wr_ok  = 1'b1;
`endif
  assign unused_wr_hi = ^(wr_addr >> ADDR_BITS);
  assign rd_word   = ld_oob ? 16'h0000 : mem[ld_addr[ADDR_BITS-1:0]];
  assign rsp_valid = state_q == S_RESP;
  assign rsp_data  = data_q;
  assign rsp_addr  = raddr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      addr_d  = req_addr;
      load    = WAIT_CYCLES == 0;
      state_d = load ? S_RESP : S_WAIT;
      cnt_d   = 4'(WAIT_CYCLES);
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      load    = cnt_q == 4'd1;
      state_d = load ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP && rsp_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (load) begin
        data_q  <= rd_word;
        raddr_q <= ld_addr;
      end
    end
  end
  // a read at the same edge as a write sees the old word
  always_ff @(posedge clock)
    if (wr_en && wr_ok) mem[wr_addr[ADDR_BITS-1:0]] <= wr_data;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed plus randomized check against a transaction model
module tb_instr_mem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;
  logic clock = 1'b0;
  logic reset, req_valid, req_ready, rsp_valid, rsp_ready, flush, wr_en;
  logic [15:0] req_addr, rsp_data, rsp_addr, wr_addr, wr_data;
`ifdef INSTR_BOUNDS_CHECK_EN
  logic rsp_err;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .ADDR_BITS(8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
`ifdef INSTR_BOUNDS_CHECK_EN
    .rsp_err(rsp_err),
`endif
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  logic [15:0] m_mem [DEPTH];
  bit          m_pend, m_have, m_err;
  logic [15:0] m_paddr, m_rdata, m_raddr;
  int          cyc = 0;
  int          m_due;
  function automatic bit exp_ready();
    return !reset && !flush && !m_pend && (!m_have || rsp_ready);
  endfunction
  function automatic bit oob(input logic [15:0] a);
`ifdef INSTR_BOUNDS_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction
  task automatic m_load(input logic [15:0] a);
    m_have  = 1;
    m_raddr = a;
    m_err   = oob(a);
    m_rdata = m_err ? 16'h0000 : m_mem[int'(a) % DEPTH];
  endtask
  task automatic model_update();
    bit acc;
    acc = req_valid && exp_ready();
    if (reset) begin
      m_pend = 0; m_have = 0; m_err = 0; m_rdata = 0; m_raddr = 0;
    end else if (flush) begin
      m_pend = 0; m_have = 0;
    end else begin
      if (m_have && rsp_ready) m_have = 0;
      if (m_pend && cyc == m_due) begin
        m_pend = 0;
        m_load(m_paddr);
      end
      if (acc) begin
        if (W == 0) m_load(req_addr);
        else begin
          m_pend = 1; m_paddr = req_addr; m_due = cyc + W;
        end
      end
    end
    if (wr_en && !oob(wr_addr)) m_mem[int'(wr_addr) % DEPTH] = wr_data;
    cyc++;
  endtask
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic check_model();
    chk("req_ready", {15'd0, req_ready}, {15'd0, exp_ready()});
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, m_have});
    chk("rsp_data", rsp_data, m_rdata);
    chk("rsp_addr", rsp_addr, m_raddr);
`ifdef INSTR_BOUNDS_CHECK_EN
    chk("rsp_err", {15'd0, rsp_err}, {15'd0, m_err});
`endif
  endtask
  task automatic tick();
    #1 check_model();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask
  task automatic idle();
    reset = 0; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0; wr_en = 0;
  endtask
  task automatic fetch(input logic [15:0] a);
    req_valid = 1; req_addr = a;
    tick();
    req_valid = 0;
    repeat (W) tick();
  endtask
  task automatic consume();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask
  initial begin
    idle();
    reset = 1; wr_addr = 0; wr_data = 0;
    m_pend = 0; m_have = 0; m_err = 0; m_rdata = 0; m_raddr = 0;
    @(posedge clock);
    model_update();
    @(negedge clock);
    tick();
    chk("reset_valid", {15'd0, rsp_valid}, 16'd0);
    chk("reset_data", rsp_data, 16'h0000);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = 16'(i);
      wr_data = (i < 4) ? 16'((i + 1) * 16'h1111) : 16'($urandom);
      tick();
    end
    wr_en = 0;
    fetch(16'd1);
    chk("lat_valid", {15'd0, rsp_valid}, 16'd1);
    chk("lat_data", rsp_data, 16'h2222);
    chk("lat_addr", rsp_addr, 16'd1);
    repeat (5) begin
      tick();
      chk("hold_data", rsp_data, 16'h2222);
      chk("hold_ready", {15'd0, req_ready}, 16'd0);
    end
    rsp_ready = 1; req_valid = 1; req_addr = 16'd2;
    #1 chk("b2b_ready", {15'd0, req_ready}, 16'd1);
    tick();
    rsp_ready = 0; req_valid = 0;
    chk("b2b_gap", {15'd0, rsp_valid}, 16'd0);
    repeat (W) tick();
    chk("b2b_data", rsp_data, 16'h3333);
    consume();
    req_valid = 1; req_addr = 16'd3;
    tick();
    req_valid = 0; flush = 1;
    tick();
    flush = 0;
    repeat (4) begin
      tick();
      chk("flush_novalid", {15'd0, rsp_valid}, 16'd0);
    end
    fetch(16'd0);
    chk("postflush_data", rsp_data, 16'h1111);
    consume();
    req_valid = 1; req_addr = 16'd1;
    tick();
    req_valid = 0;
    tick();
    wr_en = 1; wr_addr = 16'd1; wr_data = 16'hBEEF;
    tick();
    wr_en = 0;
    chk("rw_old", rsp_data, 16'h2222);
    consume();
    fetch(16'd1);
    chk("rw_new", rsp_data, 16'hBEEF);
    consume();
    fetch(16'd258);
    chk("wrap_addr", rsp_addr, 16'd258);
`ifdef INSTR_BOUNDS_CHECK_EN
    chk("oob_data", rsp_data, 16'h0000);
    chk("oob_err", {15'd0, rsp_err}, 16'd1);
`else
    chk("wrap_data", rsp_data, 16'h3333);
`endif
    consume();
    req_valid = 1; req_addr = 16'd0;
    tick();
    req_valid = 0; reset = 1;
    tick();
    reset = 0;
    #1 chk("rst_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_valid", {15'd0, rsp_valid}, 16'd0);
    repeat (4) begin
      tick();
      chk("rst_novalid", {15'd0, rsp_valid}, 16'd0);
    end
    fetch(16'd0);
    chk("rst_mem", rsp_data, 16'h1111);
    consume();
    for (int n = 0; n < 4000; n++) begin
      reset     = $urandom_range(0, 99) == 0;
      flush     = $urandom_range(0, 99) < 4;
      req_valid = $urandom_range(0, 9) < 6;
      req_addr  = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 511));
      rsp_ready = $urandom_range(0, 9) < 5;
      wr_en     = $urandom_range(0, 3) == 0;
      wr_addr   = 16'($urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 511));
      wr_data   = 16'($urandom);
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder at the far end of the program counter's fetch interface.
- Accepts a 16-bit word address (PC value) over a valid/ready request channel, waits a configurable number of wait states, then returns the instruction word over a valid/ready response channel.
- Includes a write port so the test bench or loader can fill program memory.
- Sits between the program counter and the instruction decoder.

Parameters:
- DEPTH, 256, number of 16-bit instruction words; power of two, 2..65536
- WAIT_CYCLES, 2, extra cycles between accept and response; 0..15
- ADDR_BITS, 8, log2(DEPTH); index width into memory

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request present
- req_addr  input  16  word address (PC)
- req_ready  output  1  responder can accept request this cycle
- rsp_valid  output  1  rsp_data/rsp_addr valid
- rsp_ready  input  1  consumer accepts response this cycle
- rsp_data  output  16  instruction word
- rsp_addr  output  16  address that produced rsp_data
- flush  input  1  abort in-flight fetch (branch taken)
- wr_en  input  1  program-load write enable
- wr_addr  input  16  program-load word address
- wr_data  input  16  program-load data

Behaviour:
- One clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values:
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_addr=0
  - wait counter=0
  - memory contents not cleared
- FSM states: IDLE, WAIT, RESP.
- req_ready (combinational) = !reset && !flush && (state==IDLE || (state==RESP && rsp_ready)).
- Accept = req_valid && req_ready. On accept:
  - latch req_addr into the address register
  - if WAIT_CYCLES==0, go to RESP next cycle with data read
  - otherwise go to WAIT with counter=WAIT_CYCLES
- WAIT:
  - counter decrements each cycle
  - in the cycle counter==1, read memory, load rsp_data/rsp_addr, go to RESP
- Latency: accept at cycle T gives rsp_valid=1 at T+1+WAIT_CYCLES.
- RESP:
  - rsp_valid=1; rsp_data/rsp_addr held stable until rsp_ready
  - on rsp_ready without a new accept: go to IDLE, rsp_valid=0 next cycle
  - on rsp_ready with a new accept (back-to-back): go to WAIT, or stay in RESP with new data if WAIT_CYCLES==0
- Memory index = addr[ADDR_BITS-1:0]. Upper bits ignored, so addresses wrap modulo DEPTH. rsp_addr returns the full 16-bit latched address.
- Write port:
  - wr_en writes mem[wr_addr[ADDR_BITS-1:0]] at the clock edge, independent of FSM state
  - a read and a write to the same index in the same cycle return the OLD data
  - a write in any earlier cycle of WAIT is visible in the response
- flush:
  - highest priority after reset
  - next state IDLE, rsp_valid=0 next cycle, counter cleared
  - a request presented during flush is not accepted (req_ready=0)
  - a pending response is discarded
- Reset asserted mid-WAIT or mid-RESP: all outputs return to reset values next cycle; no response is emitted for the in-flight address.
- Reset and flush together: reset behaviour applies.

Optional Feature:
- Macro: INSTR_BOUNDS_CHECK_EN.
- Defined:
  - extra output rsp_err (1 bit, reset 0), valid with rsp_valid
  - if the latched address >= DEPTH: rsp_data=16'h0000 (NOP), rsp_err=1, memory not read
  - writes with wr_addr >= DEPTH are dropped
- Undefined:
  - no rsp_err port
  - addresses wrap modulo DEPTH for both reads and writes

Test Plan:
- Reset, then load mem[0..3]=16'h1111,2222,3333,4444. With WAIT_CYCLES=2: req_addr=1 accepted at T gives rsp_valid=1 at T+3, rsp_data=16'h2222, rsp_addr=1.
- rsp_ready held 0 for 5 cycles in RESP: rsp_data stays 16'h2222 and req_ready=0 throughout. rsp_ready=1 with req_valid=1, addr=2: req_ready=1 that cycle and the next response is 16'h3333 three cycles later.
- Accept addr=3; assert flush one cycle later: rsp_valid never rises for addr 3, state is IDLE, and the next request addr=0 returns 16'h1111 with normal latency.
- wr_en to index 1 (data 16'hBEEF) in the same cycle as the read of index 1: response is 16'h2222. Refetch of 1 returns 16'hBEEF.
- req_addr=DEPTH+2 (16'd258) without the macro: rsp_data=16'h3333, rsp_addr=258. With INSTR_BOUNDS_CHECK_EN: rsp_data=0, rsp_err=1.
- Assert reset during WAIT: next cycle rsp_valid=0, req_ready=1 once reset deasserts, and memory still returns 16'h1111 for addr 0.
